wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 23, address width of all ports.
REQ-002 Parameter DATA_WIDTH, default 8, data width of all ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, max wait for slave response in cycles (1..255); 0 disables timeout.
REQ-004 clk_i  input  1  single clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 mN_cyc_i, mN_stb_i, mN_we_i  input  1 each  Wishbone master N (N=0,1) cycle/strobe/write.
REQ-007 mN_adr_i  input  ADDR_WIDTH; mN_dat_i  input  DATA_WIDTH  master N address/write data.
REQ-008 mN_ack_o, mN_err_o, mN_rty_o  output  1 each; mN_dat_o  output  DATA_WIDTH  responses to master N.
REQ-009 s_cyc_o, s_stb_o, s_we_o  output  1 each; s_adr_o  output  ADDR_WIDTH; s_dat_o  output  DATA_WIDTH  to shared slave (SPI RAM bridge).
REQ-010 s_ack_i, s_err_i, s_rty_i  input  1 each; s_dat_i  input  DATA_WIDTH  slave responses.
REQ-011 grant_o  output  2  one-hot current owner (bit N = master N); 0 when none.

Function
REQ-012 States: IDLE, OWN0, OWN1, ABORT; registered state plus last_owner bit.
REQ-013 IDLE: all s_* outputs 0; grant_o=0; all mN_ack/err/rty/dat = 0.
REQ-014 IDLE, only mN_cyc_i high -> OWNN next cycle (one-cycle grant latency).
REQ-015 IDLE, both cyc high -> grant master != last_owner (round-robin); after reset master 0 wins first tie.
REQ-016 OWNN: s_cyc/stb/we/adr/dat combinationally equal master N inputs; grant_o bit N = 1.
REQ-017 OWNN: mN_ack/err/rty/dat_o combinationally equal s_ack/err/rty/dat_i; other master's response outputs all 0.
REQ-018 OWNN held while mN_cyc_i high, covering multiple strobes (locked cycle); other master's requests ignored.
REQ-019 OWNN, mN_cyc_i low -> IDLE next cycle, last_owner<=N; s_cyc_o falls same cycle as mN_cyc_i (combinational); one IDLE bubble before any new grant.
REQ-020 Slave ack and master cyc drop in same cycle: ack still delivered to owner that cycle.
REQ-021 Timeout counter, 8 bit: cleared in IDLE, ABORT, and any cycle with s_ack_i|s_err_i|s_rty_i or s_stb_o low; else increments while s_cyc_o&s_stb_o.
REQ-022 Counter reaches TIMEOUT_CYCLES (nonzero) with no slave response -> that cycle mN_err_o=1 to owner (ack/rty forced 0), state -> ABORT next cycle.
REQ-023 ABORT: s_cyc_o/s_stb_o forced 0, all master responses 0, grant_o keeps owner bit; stays until owner cyc low, then IDLE, last_owner<=owner.
REQ-024 Counter never wraps; saturates when TIMEOUT_CYCLES=0.
REQ-025 Non-owner cyc may rise/fall anytime with no effect on current transfer.

Reset
REQ-026 rst_i high at clock edge -> next cycle state IDLE, last_owner=1, counter 0; all outputs 0.
REQ-027 Reset mid-transfer: s_cyc_o low from next cycle regardless of master inputs; slave response that cycle not forwarded.
REQ-028 Reset has priority over every other transition.

Verification
REQ-029 Bench shall cover: m0 write adr=0x000123 dat=0xA5, slave acks after 82 cycles -> s_adr_o=0x000123, s_we_o=1, m0_ack_o one cycle, m1_ack_o=0.
REQ-030 Bench shall cover: both cyc rise same cycle after reset -> grant_o=01; m0 done, IDLE one cycle, then grant_o=10; then m0 again vs m1 tie -> m0.
REQ-031 Bench shall cover: m1 owns, m0 asserts cyc mid-transfer -> no s_* change, m0 granted only after m1 cyc drops plus one IDLE cycle.
REQ-032 Bench shall cover: TIMEOUT_CYCLES=16, slave never acks -> m0_err_o=1 at cycle 16 of strobe, then s_cyc_o=0 until m0_cyc_i low.
REQ-033 Bench shall cover: rst_i pulse while OWN0 with stb high -> s_cyc_o=0 next cycle, grant_o=0, next tie granted to m0.
REQ-034 Bench shall cover: m1 read, s_dat_i=0x3C with ack -> m1_dat_o=0x3C, m0_dat_o=0x00.

Source files
------------

// File: rtl/wb_arbiter.sv
// Two-master Wishbone arbiter in front of a single shared slave (SPI RAM bridge).
// Round-robin on ties, locked ownership while the owner holds cyc, slave-response timeout with abort.
module wb_arbiter #(
  parameter int ADDR_WIDTH     = 23,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_cyc_i,
  input  logic                  m0_stb_i,
  input  logic                  m0_we_i,
  input  logic [ADDR_WIDTH-1:0] m0_adr_i,
  input  logic [DATA_WIDTH-1:0] m0_dat_i,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  output logic                  m0_rty_o,
  output logic [DATA_WIDTH-1:0] m0_dat_o,
  input  logic                  m1_cyc_i,
  input  logic                  m1_stb_i,
  input  logic                  m1_we_i,
  input  logic [ADDR_WIDTH-1:0] m1_adr_i,
  input  logic [DATA_WIDTH-1:0] m1_dat_i,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic                  m1_rty_o,
  output logic [DATA_WIDTH-1:0] m1_dat_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [ADDR_WIDTH-1:0] s_adr_o,
  output logic [DATA_WIDTH-1:0] s_dat_o,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  input  logic                  s_rty_i,
  input  logic [DATA_WIDTH-1:0] s_dat_i,
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam logic [7:0] LP_TMO    = 8'(TIMEOUT_CYCLES);
  localparam logic       LP_TMO_EN = (LP_TMO != 8'd0);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last_owner;
  logic       w_last_owner_nxt;
  logic       r_abort_owner;
  logic       w_abort_owner_nxt;
  logic [7:0] r_tmo;
  logic [7:0] w_tmo_nxt;
  logic       w_resp;
  logic       w_tmo_hit;
  logic       w_abort_cyc;

  // Next-state, timeout counter and the combinational slave/master crossbar.
  always_comb begin
    w_state_nxt       = r_state;
    w_last_owner_nxt  = r_last_owner;
    w_abort_owner_nxt = r_abort_owner;
    w_tmo_nxt         = r_tmo;
    w_resp            = s_ack_i | s_err_i | s_rty_i;
    w_tmo_hit         = 1'b0;
    w_abort_cyc       = 1'b0;
    s_cyc_o           = 1'b0;
    s_stb_o           = 1'b0;
    s_we_o            = 1'b0;
    s_adr_o           = '0;
    s_dat_o           = '0;
    grant_o           = 2'b00;
    m0_ack_o          = 1'b0;
    m0_err_o          = 1'b0;
    m0_rty_o          = 1'b0;
    m0_dat_o          = '0;
    m1_ack_o          = 1'b0;
    m1_err_o          = 1'b0;
    m1_rty_o          = 1'b0;
    m1_dat_o          = '0;

    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_state_nxt = r_last_owner ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          w_state_nxt = OWN0;
        end else if (m1_cyc_i) begin
          w_state_nxt = OWN1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      OWN0: begin
        s_cyc_o   = m0_cyc_i;
        s_stb_o   = m0_stb_i;
        s_we_o    = m0_we_i;
        s_adr_o   = m0_adr_i;
        s_dat_o   = m0_dat_i;
        grant_o   = 2'b01;
        w_tmo_hit = LP_TMO_EN && m0_cyc_i && m0_stb_i && !w_resp && (r_tmo == LP_TMO - 8'd1);
        m0_ack_o  = s_ack_i & ~w_tmo_hit;
        m0_err_o  = s_err_i | w_tmo_hit;
        m0_rty_o  = s_rty_i & ~w_tmo_hit;
        m0_dat_o  = s_dat_i;
        if (w_tmo_hit) begin
          w_state_nxt       = ABORT;
          w_abort_owner_nxt = 1'b0;
        end else if (!m0_cyc_i) begin
          w_state_nxt      = IDLE;
          w_last_owner_nxt = 1'b0;
        end else begin
          w_state_nxt = OWN0;
        end
      end
      OWN1: begin
        s_cyc_o   = m1_cyc_i;
        s_stb_o   = m1_stb_i;
        s_we_o    = m1_we_i;
        s_adr_o   = m1_adr_i;
        s_dat_o   = m1_dat_i;
        grant_o   = 2'b10;
        w_tmo_hit = LP_TMO_EN && m1_cyc_i && m1_stb_i && !w_resp && (r_tmo == LP_TMO - 8'd1);
        m1_ack_o  = s_ack_i & ~w_tmo_hit;
        m1_err_o  = s_err_i | w_tmo_hit;
        m1_rty_o  = s_rty_i & ~w_tmo_hit;
        m1_dat_o  = s_dat_i;
        if (w_tmo_hit) begin
          w_state_nxt       = ABORT;
          w_abort_owner_nxt = 1'b1;
        end else if (!m1_cyc_i) begin
          w_state_nxt      = IDLE;
          w_last_owner_nxt = 1'b1;
        end else begin
          w_state_nxt = OWN1;
        end
      end
      ABORT: begin
        // The slave is cut off; the aborted master keeps its grant bit until it releases cyc.
        grant_o     = r_abort_owner ? 2'b10 : 2'b01;
        w_abort_cyc = r_abort_owner ? m1_cyc_i : m0_cyc_i;
        if (!w_abort_cyc) begin
          w_state_nxt      = IDLE;
          w_last_owner_nxt = r_abort_owner;
        end else begin
          w_state_nxt = ABORT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if ((r_state == IDLE) || (r_state == ABORT) || w_resp || !(s_cyc_o && s_stb_o)) begin
      w_tmo_nxt = 8'd0;
    end else if (r_tmo != 8'hFF) begin
      w_tmo_nxt = r_tmo + 8'd1;
    end else begin
      w_tmo_nxt = r_tmo;
    end
  end

  // State, round-robin history, abort owner and timeout counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_last_owner  <= 1'b1;
      r_abort_owner <= 1'b0;
      r_tmo         <= 8'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_last_owner  <= w_last_owner_nxt;
      r_abort_owner <= w_abort_owner_nxt;
      r_tmo         <= w_tmo_nxt;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: two instances (default timeout and timeout 16) share stimulus
// and are checked every cycle against an ownership-level model, plus literal spot checks.
module tb_wb_arbiter;

  localparam int AW    = 23;
  localparam int DW    = 8;
  localparam int TMO_A = 255;
  localparam int TMO_B = 16;

  logic          clk;
  logic          rst;
  logic          m0_cyc, m0_stb, m0_we;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat;
  logic          m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat;
  logic          s_ack, s_err, s_rty;
  logic [DW-1:0] s_dat;

  logic          a_m0_ack, a_m0_err, a_m0_rty, a_m1_ack, a_m1_err, a_m1_rty;
  logic [DW-1:0] a_m0_dat, a_m1_dat, a_s_dat;
  logic          a_s_cyc, a_s_stb, a_s_we;
  logic [AW-1:0] a_s_adr;
  logic [1:0]    a_grant;
  logic          b_m0_ack, b_m0_err, b_m0_rty, b_m1_ack, b_m1_err, b_m1_rty;
  logic [DW-1:0] b_m0_dat, b_m1_dat, b_s_dat;
  logic          b_s_cyc, b_s_stb, b_s_we;
  logic [AW-1:0] b_s_adr;
  logic [1:0]    b_grant;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO_A)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err), .m0_rty_o(a_m0_rty), .m0_dat_o(a_m0_dat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err), .m1_rty_o(a_m1_rty), .m1_dat_o(a_m1_dat),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr), .s_dat_o(a_s_dat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_dat),
    .grant_o(a_grant)
  );

  wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO_B)) u_dut16 (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err), .m0_rty_o(b_m0_rty), .m0_dat_o(b_m0_dat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err), .m1_rty_o(b_m1_rty), .m1_dat_o(b_m1_dat),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr), .s_dat_o(b_s_dat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_dat_i(s_dat),
    .grant_o(b_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [57:0] act_v [2];
  assign act_v[0] = {a_s_cyc, a_s_stb, a_s_we, a_s_adr, a_s_dat, a_grant,
                     a_m0_ack, a_m0_err, a_m0_rty, a_m0_dat, a_m1_ack, a_m1_err, a_m1_rty, a_m1_dat};
  assign act_v[1] = {b_s_cyc, b_s_stb, b_s_we, b_s_adr, b_s_dat, b_grant,
                     b_m0_ack, b_m0_err, b_m0_rty, b_m0_dat, b_m1_ack, b_m1_err, b_m1_rty, b_m1_dat};

  // Model: who owns the slave (-1 none), whether that owner was aborted, last finished owner,
  // and how many cycles the current strobe has waited without a slave response.
  int mo_owner [2];
  bit mo_abort [2];
  int mo_last  [2];
  int mo_wait  [2];
  bit model_valid = 1'b0;

  function automatic int tmo_of(input int k);
    return (k == 0) ? TMO_A : TMO_B;
  endfunction

  function automatic bit owner_cyc(input int k);
    return (mo_owner[k] == 0) ? m0_cyc : m1_cyc;
  endfunction

  function automatic bit model_timeout(input int k);
    bit stb_on;
    stb_on = (mo_owner[k] == 0) ? (m0_cyc && m0_stb) : (m1_cyc && m1_stb);
    return (mo_owner[k] >= 0) && !mo_abort[k] && (tmo_of(k) != 0) && stb_on &&
           !(s_ack || s_err || s_rty) && (mo_wait[k] + 1 == tmo_of(k));
  endfunction

  function automatic logic [57:0] model_out(input int k);
    logic          sc, ss, sw, to;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd, d0, d1;
    logic [1:0]    g;
    logic [2:0]    r0, r1;
    {sc, ss, sw, sa, sd, g, r0, d0, r1, d1} = '0;
    if (mo_owner[k] >= 0) g = (mo_owner[k] == 0) ? 2'b01 : 2'b10;
    if (mo_owner[k] >= 0 && !mo_abort[k]) begin
      if (mo_owner[k] == 0) {sc, ss, sw, sa, sd} = {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat};
      else                  {sc, ss, sw, sa, sd} = {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat};
      to = model_timeout(k);
      if (mo_owner[k] == 0) begin
        r0 = {s_ack & ~to, s_err | to, s_rty & ~to};
        d0 = s_dat;
      end else begin
        r1 = {s_ack & ~to, s_err | to, s_rty & ~to};
        d1 = s_dat;
      end
    end
    return {sc, ss, sw, sa, sd, g, r0, d0, r1, d1};
  endfunction

  // Advance the model on each rising edge using the inputs that were stable before it.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [57:0] ev;
      bit          to;
      bit          resp;
      ev   = model_out(k);
      to   = model_timeout(k);
      resp = s_ack || s_err || s_rty;
      if (rst) begin
        mo_owner[k] = -1;
        mo_abort[k] = 1'b0;
        mo_last[k]  = 1;
        mo_wait[k]  = 0;
        model_valid = 1'b1;
      end else begin
        if (mo_owner[k] < 0 || mo_abort[k] || resp || !(ev[57] && ev[56])) mo_wait[k] = 0;
        else if (mo_wait[k] < 255) mo_wait[k] = mo_wait[k] + 1;
        if (mo_owner[k] < 0) begin
          if (m0_cyc && m1_cyc) mo_owner[k] = (mo_last[k] == 0) ? 1 : 0;
          else if (m0_cyc)      mo_owner[k] = 0;
          else if (m1_cyc)      mo_owner[k] = 1;
        end else if (mo_abort[k]) begin
          if (!owner_cyc(k)) begin
            mo_last[k]  = mo_owner[k];
            mo_owner[k] = -1;
            mo_abort[k] = 1'b0;
          end
        end else if (to) begin
          mo_abort[k] = 1'b1;
        end else if (!owner_cyc(k)) begin
          mo_last[k]  = mo_owner[k];
          mo_owner[k] = -1;
        end
      end
    end
  end

  // Compare every output of both instances against the model on the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      for (int k = 0; k < 2; k++) begin
        logic [57:0] ev;
        ev = model_out(k);
        checks++;
        if (act_v[k] !== ev) begin
          errors++;
          $display("FAIL model_cmp inst%0d t=%0t actual=%h required=%h", k, $time, act_v[k], ev);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_all();
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we} = 6'b0;
    m0_adr = '0; m0_dat = '0; m1_adr = '0; m1_dat = '0;
    {s_ack, s_err, s_rty} = 3'b0;
    s_dat = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    step();
    step();
    rst = 1'b0;
    settle();
    chk("rst_grant", 32'(a_grant), 32'h0);
    chk("rst_scyc", 32'(a_s_cyc), 32'h0);
    chk("rst_grant16", 32'(b_grant), 32'h0);

    // m0 write, ack after 82 owned cycles, cyc dropped in the ack cycle
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 23'h000123; m0_dat = 8'hA5;
    step();
    settle();
    chk("wr_grant", 32'(a_grant), 32'h1);
    chk("wr_adr", 32'(a_s_adr), 32'h000123);
    chk("wr_we", 32'(a_s_we), 32'h1);
    chk("wr_dat", 32'(a_s_dat), 32'hA5);
    repeat (80) step();
    step();
    s_ack = 1'b1; m0_cyc = 1'b0; m0_stb = 1'b0;
    settle();
    chk("wr_ack_m0", 32'(a_m0_ack), 32'h1);
    chk("wr_ack_m1", 32'(a_m1_ack), 32'h0);
    chk("wr_scyc_drop", 32'(a_s_cyc), 32'h0);
    step();
    idle_all();
    settle();
    chk("wr_ack_once", 32'(a_m0_ack), 32'h0);
    chk("wr_idle_grant", 32'(a_grant), 32'h0);
    chk("wr_idle_grant16", 32'(b_grant), 32'h0);

    // reset, then simultaneous requests: m0, bubble, m1 (read 0x3C), then tie back to m0
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 23'h000010; m0_dat = 8'h11;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 23'h000020;
    step();
    settle();
    chk("tie_grant", 32'(a_grant), 32'h1);
    chk("tie_grant16", 32'(b_grant), 32'h1);
    chk("tie_adr", 32'(a_s_adr), 32'h000010);
    step();
    s_ack = 1'b1;
    settle();
    chk("tie_ack_m0", 32'(a_m0_ack), 32'h1);
    chk("tie_ack_m1", 32'(a_m1_ack), 32'h0);
    step();
    s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    settle();
    chk("rr_bubble", 32'(a_grant), 32'h0);
    step();
    s_ack = 1'b1; s_dat = 8'h3C;
    settle();
    chk("rr_grant_m1", 32'(a_grant), 32'h2);
    chk("rd_we", 32'(a_s_we), 32'h0);
    chk("rd_m1_dat", 32'(a_m1_dat), 32'h3C);
    chk("rd_m0_dat", 32'(a_m0_dat), 32'h00);
    chk("rd_m1_ack", 32'(a_m1_ack), 32'h1);
    step();
    s_ack = 1'b0; s_dat = 8'h00; m1_cyc = 1'b0; m1_stb = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    step();
    m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    settle();
    chk("rr_tie_m0", 32'(a_grant), 32'h1);
    step();
    idle_all();
    step();

    // m1 owns; m0 requests mid-transfer and must wait for release plus one idle cycle
    step();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 23'h000456; m1_dat = 8'h77;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 23'h000111; m0_dat = 8'h99;
    settle();
    chk("lock_grant", 32'(a_grant), 32'h2);
    chk("lock_adr", 32'(a_s_adr), 32'h000456);
    step();
    settle();
    chk("lock_dat", 32'(a_s_dat), 32'h77);
    step();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    settle();
    chk("lock_scyc_drop", 32'(a_s_cyc), 32'h0);
    chk("lock_grant_drop", 32'(a_grant), 32'h2);
    step();
    settle();
    chk("lock_bubble", 32'(a_grant), 32'h0);
    step();
    settle();
    chk("lock_m0_grant", 32'(a_grant), 32'h1);
    chk("lock_m0_adr", 32'(a_s_adr), 32'h000111);
    step();
    idle_all();
    step();

    // slave never answers: timeout-16 instance errors on strobe cycle 16, then aborts
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 23'h000042;
    step();
    repeat (14) step();
    settle();
    chk("tmo_err_c15", 32'(b_m0_err), 32'h0);
    step();
    settle();
    chk("tmo_err_c16", 32'(b_m0_err), 32'h1);
    chk("tmo_ack_c16", 32'(b_m0_ack), 32'h0);
    chk("tmo_err_default", 32'(a_m0_err), 32'h0);
    step();
    settle();
    chk("abort_scyc", 32'(b_s_cyc), 32'h0);
    chk("abort_sstb", 32'(b_s_stb), 32'h0);
    chk("abort_grant", 32'(b_grant), 32'h1);
    chk("abort_err", 32'(b_m0_err), 32'h0);
    chk("abort_default_scyc", 32'(a_s_cyc), 32'h1);
    repeat (3) step();
    settle();
    chk("abort_hold", 32'(b_s_cyc), 32'h0);
    step();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    settle();
    chk("abort_exit16", 32'(b_grant), 32'h0);
    chk("abort_exit", 32'(a_grant), 32'h0);

    // reset while m0 owns with stb high and the slave acking
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 23'h000077;
    step();
    settle();
    chk("mrst_own", 32'(a_grant), 32'h1);
    step();
    rst = 1'b1; s_ack = 1'b1;
    step();
    rst = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
    settle();
    chk("mrst_scyc", 32'(a_s_cyc), 32'h0);
    chk("mrst_grant", 32'(a_grant), 32'h0);
    chk("mrst_noack", 32'(a_m0_ack), 32'h0);
    step();
    s_ack = 1'b0;
    settle();
    chk("mrst_tie_m0", 32'(a_grant), 32'h1);
    chk("mrst_tie_m0_16", 32'(b_grant), 32'h1);
    step();
    idle_all();
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
